// File: rtl/xbuf_alloc.sv
// Buffer-slot allocator: circular free list plus round-robin grant of one slot per cycle.
// Optional XBA_DUP_CHK_EN adds an allocation map that rejects double or invalid frees.
module xbuf_alloc #(
    parameter  int NUM_REQ = 4,
    parameter  int DEPTH   = 8,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    input  logic               rel_vld,
    input  logic [IW-1:0]      rel_idx,
    output logic               rel_err,
    output logic [IW:0]        free_cnt,
    output logic               avail
);

    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] fl_mem [DEPTH];
    logic [IW:0]   rptr, wptr, rptr_n, wptr_n, free_n;
    logic [RW-1:0] rr_ptr, win, cand, rr_nxt;
    logic          found, alloc, full, rel_ok;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = RW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (!rst && avail && found)
            gnt[win] = 1'b1;
    end

    assign gnt_idx = fl_mem[rptr[IW-1:0]];
    assign alloc   = |gnt;
    assign rr_nxt  = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

    // Full when the wrap bits differ and the slot bits match.
    assign full = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);

`ifdef XBA_DUP_CHK_EN
    logic [DEPTH-1:0] alloc_map, alloc_map_n;

    // A slot granted this same cycle counts as allocated for the release check.
    assign rel_ok = rel_vld && !full &&
                    (alloc_map[rel_idx] || (alloc && (gnt_idx == rel_idx)));

    always_comb begin
        alloc_map_n = alloc_map;
        if (alloc)
            alloc_map_n[gnt_idx] = 1'b1;
        if (rel_ok)
            alloc_map_n[rel_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            alloc_map <= '0;
        else
            alloc_map <= alloc_map_n;
    end
`else
    assign rel_ok = rel_vld && !full;
`endif

    assign rptr_n = rptr + {{IW{1'b0}}, alloc};
    assign wptr_n = wptr + {{IW{1'b0}}, rel_ok};
    assign free_n = wptr_n - rptr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                fl_mem[i] <= IW'(i);
            rptr     <= '0;
            wptr     <= {1'b1, {IW{1'b0}}};
            rr_ptr   <= '0;
            rel_err  <= 1'b0;
            free_cnt <= {1'b1, {IW{1'b0}}};
            avail    <= 1'b1;
        end else begin
            if (rel_ok)
                fl_mem[wptr[IW-1:0]] <= rel_idx;
            if (alloc)
                rr_ptr <= rr_nxt;
            rptr     <= rptr_n;
            wptr     <= wptr_n;
            rel_err  <= rel_vld && !rel_ok;
            free_cnt <= free_n;
            avail    <= |free_n;
        end
    end

endmodule

// File: tb/tb_xbuf_alloc.sv
// Directed and random stimulus for xbuf_alloc against a queue-based free-list model.
module tb_xbuf_alloc;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          rel_vld;
    logic [IW-1:0] rel_idx;
    logic          rel_err;
    logic [IW:0]   free_cnt;
    logic          avail;

    xbuf_alloc #(.NUM_REQ(N), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_idx(gnt_idx),
        .rel_vld(rel_vld), .rel_idx(rel_idx), .rel_err(rel_err),
        .free_cnt(free_cnt), .avail(avail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int       free_q[$];
    int       rr;
    bit       err_m;
    bit [D-1:0] map_m;
    logic [N-1:0]  obs_gnt;
    logic [IW-1:0] obs_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        for (int i = 0; i < D; i++) free_q.push_back(i);
        rr    = 0;
        err_m = 1'b0;
        map_m = '0;
    endtask

    task automatic cycle();
        int w;
        int gidx;
        bit full_m;
        bit ok;
        w = -1;
        if (!rst && free_q.size() != 0)
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (w < 0 && req[c]) w = c;
            end
        @(negedge clk);
        obs_gnt = gnt;
        obs_idx = gnt_idx;
        chk("gnt", gnt, (w < 0) ? 0 : (1 << w));
        if (w >= 0) chk("gnt_idx", gnt_idx, free_q[0]);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            full_m = (free_q.size() == D);
            if (w >= 0) begin
                gidx = free_q.pop_front();
                map_m[gidx] = 1'b1;
                rr = (w + 1) % N;
            end
            ok = rel_vld && !full_m;
`ifdef XBA_DUP_CHK_EN
            ok = ok && map_m[rel_idx];
`endif
            if (ok) begin
                free_q.push_back(int'(rel_idx));
                map_m[rel_idx] = 1'b0;
            end
            err_m = rel_vld && !ok;
        end
        #1;
        chk("free_cnt", free_cnt, free_q.size());
        chk("avail", avail, (free_q.size() != 0) ? 1 : 0);
        chk("rel_err", rel_err, err_m);
    endtask

    task automatic drive(input logic r, input logic [N-1:0] q, input logic v, input int idx);
        rst     = r;
        req     = q;
        rel_vld = v;
        rel_idx = IW'(idx);
    endtask

    initial begin
        int pick[$];
        model_reset();
        drive(1, '0, 0, 0);
        cycle();
        chk("reset_free_cnt", free_cnt, 8);
        chk("reset_avail", avail, 1);

        // Release into the full list right after reset.
        drive(0, '0, 1, 0);
        cycle();
        chk("full_rel_err", rel_err, 1);
        chk("full_rel_cnt", free_cnt, 8);
        drive(0, '0, 0, 0);
        cycle();
        chk("rel_err_pulse", rel_err, 0);

        // Round-robin drain of all eight slots.
        for (int c = 0; c < 8; c++) begin
            drive(0, 4'b1111, 0, 0);
            cycle();
            chk("rr_seq_gnt", obs_gnt, 1 << (c % 4));
            chk("rr_seq_idx", obs_idx, c);
        end
        chk("drained_avail", avail, 0);

        // No bypass: release into empty list grants only on the following cycle.
        drive(0, 4'b0010, 1, 5);
        cycle();
        chk("no_bypass", obs_gnt, 0);
        drive(0, 4'b0010, 0, 0);
        cycle();
        chk("post_rel_gnt", obs_gnt, 4'b0010);
        chk("post_rel_idx", obs_idx, 5);

        foreach (pick[i]) pick.delete(i);
        for (int c = 0; c < 3; c++) begin
            drive(0, '0, 1, (c == 0) ? 1 : c + 2);
            cycle();
        end
        drive(0, 4'b0001, 1, 2);
        cycle();
        chk("same_cycle_idx", obs_idx, 1);
        chk("same_cycle_cnt", free_cnt, 3);
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b0001, 0, 0);
            cycle();
            chk("fifo_order", obs_idx, (c == 0) ? 3 : ((c == 1) ? 4 : 2));
        end

        // Double free after a single allocation.
        drive(1, '0, 0, 0);
        cycle();
        drive(0, 4'b0001, 0, 0);
        cycle();
        drive(0, '0, 1, 0);
        cycle();
        drive(0, '0, 1, 0);
        cycle();
        chk("dup_rel_err", rel_err, 1);
        chk("dup_free_cnt", free_cnt, 8);

        // Mid-operation reset with five slots out.
        for (int c = 0; c < 5; c++) begin
            drive(0, 4'b1111, 0, 0);
            cycle();
        end
        drive(1, 4'b1111, 0, 0);
        cycle();
        chk("mid_rst_cnt", free_cnt, 8);
        drive(0, 4'b1111, 0, 0);
        cycle();
        chk("mid_rst_gnt", obs_gnt, 4'b0001);
        chk("mid_rst_idx", obs_idx, 0);

        for (int c = 0; c < 600; c++) begin
            int idx;
            pick.delete();
            for (int i = 0; i < D; i++) if (map_m[i]) pick.push_back(i);
            if (pick.size() != 0 && $urandom_range(0, 3) != 0)
                idx = pick[$urandom_range(0, pick.size() - 1)];
            else
                idx = $urandom_range(0, D - 1);
            drive(($urandom_range(0, 99) == 0), N'($urandom),
                  ($urandom_range(0, 2) == 0), idx);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
